// File: rtl/gb_rd_pkg.sv
// gb_rd_pkg: shared state encoding and default sizes for the global-buffer read controller
package gb_rd_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READY = 2'b01,
        READ  = 2'b11
    } state_t;
    localparam int ADDR_W_DEF   = 9;
    localparam int BEAT_W_DEF   = 2;
    localparam int NUM_BANK_DEF = 4;
    localparam int CYC_W_DEF    = 8;
endpackage

// File: rtl/gb_rd_seq.sv
// gb_rd_seq: steps the served bank on each bank_done and counts passes until the last one completes
module gb_rd_seq
    import gb_rd_pkg::*;
#(
    parameter int NUM_BANK = NUM_BANK_DEF,
    parameter int CYC_W    = CYC_W_DEF,
    localparam int BW      = $clog2(NUM_BANK)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            bank_done,
    input  logic [BW:0]     bank_num,
    input  logic [CYC_W-1:0] cyc_num,
    output logic [BW-1:0]   rd_bank,
    output logic [CYC_W-1:0] cyc,
    output logic            all_done
);
    logic [BW:0]      bank_last;
    logic [CYC_W-1:0] cyc_last;
    logic             wrap;

    assign bank_last = (bank_num == '0) ? '0 : bank_num - 1'b1;
    assign cyc_last  = (cyc_num == '0) ? '0 : cyc_num - 1'b1;
    // the physical bank count also bounds the sequence if bank_num is oversized
    assign wrap = ({1'b0, rd_bank} >= bank_last) || (rd_bank == BW'(NUM_BANK - 1));

    always_ff @(posedge clk) begin
        if (rst || start) begin
            rd_bank  <= '0;
            cyc      <= '0;
            all_done <= 1'b0;
        end else if (bank_done) begin
            rd_bank <= wrap ? '0 : rd_bank + 1'b1;
            if (wrap && cyc == cyc_last)
                all_done <= 1'b1;
            else if (wrap)
                cyc <= cyc + 1'b1;
        end
    end
endmodule

// File: rtl/gb_rd_ctrl_p.sv
// gb_rd_ctrl_p: reads each prepared SRAM bank word by word and feeds it to the PE as beats
module gb_rd_ctrl_p
    import gb_rd_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BEAT_W   = BEAT_W_DEF,
    parameter int NUM_BANK = NUM_BANK_DEF,
    parameter int CYC_W    = CYC_W_DEF,
    localparam int BW      = $clog2(NUM_BANK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] words_num,
    input  logic [BEAT_W-1:0] beats_num,
    input  logic [BW:0]       bank_num,
    input  logic [CYC_W-1:0]  cyc_num,
    input  logic [NUM_BANK-1:0] bank_prepare,
    input  logic              pull_back,
    input  logic              pe_rdy,
    output logic              pe_val,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [BW-1:0]     rd_bank,
    output logic [BEAT_W-1:0] beat_idx,
    output logic [1:0]        state,
    output logic              bank_done,
    output logic              all_done,
    output logic [CYC_W-1:0]  cyc
);
    state_t              st, st_nx;
    logic [ADDR_W-1:0]   words_q, word_idx;
    logic [BEAT_W-1:0]   beats_q, beat;
    logic [BW:0]         banks_q;
    logic [CYC_W-1:0]    cycs_q;
    logic [NUM_BANK-1:0] prep_q;
    logic                xfer, last_xfer, go;

    assign state  = st;
    assign pe_val = st == READ;
    assign xfer   = pe_val & pe_rdy & ~rst & ~start;
    assign rd_en  = xfer & (beat == '0);
    // rd_addr already points past the current word once its first beat is out
    assign word_idx  = (beat == '0) ? rd_addr : rd_addr - 1'b1;
    assign last_xfer = xfer & (beat == beats_q) & (word_idx == words_q - 1'b1);
    assign bank_done = ~rst & ~start & ((pull_back & (st != IDLE)) | last_xfer);
    assign go = prep_q[rd_bank] & bank_prepare[rd_bank] & ~all_done & ~start;

    always_comb begin
        st_nx = bank_done ? IDLE :
                (st == IDLE && go) ? READY :
                (st == READY && pe_rdy) ? READ : st;
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            st       <= IDLE;
            rd_addr  <= '0;
            beat     <= '0;
            beat_idx <= '0;
            prep_q   <= '0;
        end else begin
            st     <= st_nx;
            prep_q <= bank_prepare;
            if (xfer)
                beat_idx <= beat;
            if (bank_done) begin
                rd_addr <= '0;
                beat    <= '0;
            end else begin
                if (rd_en)
                    rd_addr <= rd_addr + 1'b1;
                if (xfer)
                    beat <= (beat == beats_q) ? '0 : beat + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            words_q <= '0;
            beats_q <= '0;
            banks_q <= (BW + 1)'(1);
            cycs_q  <= CYC_W'(1);
        end else if (start) begin
            words_q <= words_num;
            beats_q <= beats_num;
            banks_q <= bank_num;
            cycs_q  <= cyc_num;
        end
    end

    gb_rd_seq #(.NUM_BANK(NUM_BANK), .CYC_W(CYC_W)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bank_done(bank_done),
        .bank_num (banks_q),
        .cyc_num  (cycs_q),
        .rd_bank  (rd_bank),
        .cyc      (cyc),
        .all_done (all_done)
    );
endmodule
